duck_game_ctrl: RTL

//  Game sequencer for the duck-hunt top level. Sits between the raw push-buttons (izq, der, fire)
//  and the VGA sprite/pixel datapath. Owns crosshair position, shot budget, hit detection,

---
 rtl/duck_pkg.sv | 22 ++
 rtl/btn_sync.sv | 29 ++
 rtl/duck_game_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/duck_pkg.sv
// Shared definitions for the duck-hunt game: sequencer states and screen/sprite geometry
// defaults used by the controller, renderer and duck mover.
package duck_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        FLASH,
        HIT,
        MISS,
        OVER
    } state_t;

    localparam int unsigned SCREEN_W_DEF = 640;
    localparam int unsigned CROSS_W_DEF  = 16;
    localparam int unsigned DUCK_W_DEF   = 32;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for a raw push-button plus a rising-edge strobe on the synced level.
module btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;

endmodule

// File: rtl/duck_game_ctrl.sv
// Duck-hunt game sequencer: crosshair movement, shot budget, hit test, score/miss
// tracking and the duck freeze/respawn handshake.
module duck_game_ctrl
    import duck_pkg::*;
#(
    parameter int unsigned SCREEN_W    = SCREEN_W_DEF,
    parameter int unsigned CROSS_W     = CROSS_W_DEF,
    parameter int unsigned DUCK_W      = DUCK_W_DEF,
    parameter int unsigned CROSS_STEP  = 4,
    parameter int unsigned SHOTS       = 3,
    parameter int unsigned MAX_MISSES  = 3,
    parameter int unsigned HOLD_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       izq,
    input  logic       der,
    input  logic       fire,
    input  logic       frame_tick,
    input  logic [9:0] duck_x,
    output logic [9:0] cross_x,
    output logic       flash,
    output logic       duck_freeze,
    output logic       duck_respawn,
    output logic [1:0] shots_left,
    output logic       game_over,
    output logic [7:0] led
);

    localparam logic [10:0] X_MAX      = 11'(SCREEN_W - CROSS_W);
    localparam logic [9:0]  X_INIT     = 10'((SCREEN_W - CROSS_W) / 2);
    localparam logic [10:0] STEP       = 11'(CROSS_STEP);
    localparam logic [10:0] CW         = 11'(CROSS_W);
    localparam logic [10:0] DW         = 11'(DUCK_W);
    localparam logic [1:0]  SHOTS_INIT = 2'(SHOTS);
    localparam int unsigned MISS_W     = $clog2(MAX_MISSES + 1);
    localparam int unsigned HOLD_W     = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MAX_MISSES);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);

    logic       izq_s, der_s, fire_e;
    logic [1:0] rise_unused;

    btn_sync u_sync_izq  (.clk(clk), .reset(reset), .btn(izq),  .level(izq_s), .rise(rise_unused[0]));
    btn_sync u_sync_der  (.clk(clk), .reset(reset), .btn(der),  .level(der_s), .rise(rise_unused[1]));
    btn_sync u_sync_fire (.clk(clk), .reset(reset), .btn(fire), .level(),      .rise(fire_e));

    state_t            state, state_d;
    logic [9:0]        cross_d;
    logic [1:0]        shots, shots_d;
    logic [7:0]        score, score_d;
    logic [MISS_W-1:0] misses, misses_d;
    logic [HOLD_W-1:0] hold, hold_d;
    logic              hit_q, hit_d;
    logic              respawn_q, respawn_d;
    logic [10:0]       cross_ext, duck_ext;
    logic              hit_now;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cross_x   <= X_INIT;
            shots     <= SHOTS_INIT;
            score     <= '0;
            misses    <= '0;
            hold      <= '0;
            hit_q     <= 1'b0;
            respawn_q <= 1'b0;
        end else begin
            state     <= state_d;
            cross_x   <= cross_d;
            shots     <= shots_d;
            score     <= score_d;
            misses    <= misses_d;
            hold      <= hold_d;
            hit_q     <= hit_d;
            respawn_q <= respawn_d;
        end
    end

    // 11-bit arithmetic keeps the clamp and overlap tests free of wrap-around;
    // the hit test always sees the pre-move crosshair.
    always_comb begin
        cross_ext = {1'b0, cross_x};
        duck_ext  = {1'b0, duck_x};
        hit_now   = (duck_ext + DW > cross_ext) && (duck_ext < cross_ext + CW);

        cross_d = cross_x;
        if (frame_tick && (state == PLAY || state == FLASH)) begin
            if (izq_s && !der_s)
                cross_d = (cross_ext < STEP) ? '0 : 10'(cross_ext - STEP);
            else if (der_s && !izq_s)
                cross_d = (cross_ext + STEP > X_MAX) ? X_MAX[9:0] : 10'(cross_ext + STEP);
        end
    end

    always_comb begin
        state_d   = state;
        shots_d   = shots;
        score_d   = score;
        misses_d  = misses;
        hold_d    = hold;
        hit_d     = hit_q;
        respawn_d = 1'b0;
        unique case (state)
            IDLE, OVER: begin
                if (fire_e) begin
                    state_d   = PLAY;
                    score_d   = '0;
                    misses_d  = '0;
                    shots_d   = SHOTS_INIT;
                    respawn_d = 1'b1;
                end
            end
            PLAY: begin
                if (fire_e && shots != '0) begin
                    state_d = FLASH;
                    shots_d = shots - 2'd1;
                    hit_d   = hit_now;
                end
            end
            FLASH: begin
                if (frame_tick) begin
                    hold_d = '0;
                    if (hit_q) begin
                        state_d = HIT;
                        score_d = sat_inc8(score);
                    end else if (shots == '0) begin
                        state_d  = MISS;
                        misses_d = misses + MISS_W'(1);
                    end else begin
                        state_d = PLAY;
                    end
                end
            end
            HIT, MISS: begin
                if (frame_tick) begin
                    if (hold == HOLD_LAST) begin
                        if (state == MISS && misses == MISS_LIMIT) begin
                            state_d = OVER;
                        end else begin
                            state_d   = PLAY;
                            shots_d   = SHOTS_INIT;
                            respawn_d = 1'b1;
                        end
                    end else begin
                        hold_d = hold + HOLD_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign flash        = (state == FLASH);
    assign duck_freeze  = (state == HIT) || (state == MISS);
    assign game_over    = (state == OVER);
    assign duck_respawn = respawn_q;
    assign shots_left   = shots;
    assign led          = score;

endmodule
